// File: rtl/mux_rr_arbiter_if.sv
// Shared-bus arbitration interface: request vector from the requesters,
// one-hot grant back, plus the select/enable pair that steers the bus mux.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en;

    // Requester side: drives requests, observes grant and mux controls.
    modport master (
        output req,
        input  grant,
        input  sel,
        input  en
    );

    // Arbiter side: observes requests, drives grant and mux controls.
    modport slave (
        input  req,
        output grant,
        output sel,
        output en
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a 32-bit 4:1 muxed bus. A grant lasts while the owner
// keeps requesting, up to MAX_BURST consecutive cycles. On release the next
// requester is handed the bus on the same edge, so there is no idle bubble.
// All outputs come straight from flops; req never reaches them combinationally.
module mux_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_arbiter_if.slave    bus
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [3:0] grant_r;
    logic [1:0] sel_r;
    logic       en_r;
    logic [1:0] ptr_r;
    logic [7:0] cnt_r;

    logic [1:0] idle_pick_s;
    logic [1:0] hand_pick_s;
    logic       hold_s;

    // First set bit of v, scanning p, p+1, p+2, p+3 (mod 4).
    function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (v[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] k);
        one_hot = 4'b0001 << k;
    endfunction

    // Arbitration decisions. In GRANT, sel_r is the owner index. The handoff
    // candidate set is simply req: if the owner dropped its request, its bit
    // is already clear; on burst expiry it stays eligible and is re-granted
    // when it is the only requester.
    always_comb begin
        idle_pick_s = pick(bus.req, ptr_r);
        hand_pick_s = pick(bus.req, sel_r + 2'd1);
        hold_s      = bus.req[sel_r] && (cnt_r < MAX_CNT);
    end

    // Arbiter state machine with registered grant/sel/en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            grant_r <= 4'b0000;
            sel_r   <= 2'd0;
            en_r    <= 1'b0;
            ptr_r   <= 2'd0;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req != 4'b0000) begin
                        state_r <= GRANT;
                        grant_r <= one_hot(idle_pick_s);
                        sel_r   <= idle_pick_s;
                        en_r    <= 1'b1;
                        cnt_r   <= 8'd1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (hold_s) begin
                        cnt_r <= cnt_r + 8'd1;
                    end else begin
                        ptr_r <= sel_r + 2'd1;
                        if (bus.req != 4'b0000) begin
                            grant_r <= one_hot(hand_pick_s);
                            sel_r   <= hand_pick_s;
                            en_r    <= 1'b1;
                            cnt_r   <= 8'd1;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 4'b0000;
                            en_r    <= 1'b0;
                            cnt_r   <= 8'd0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 4'b0000;
                    en_r    <= 1'b0;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.grant = grant_r;
    assign bus.sel   = sel_r;
    assign bus.en    = en_r;

endmodule
